// File: rtl/reaction_round_scheduler_pkg.sv
// Shared definitions for the reaction round scheduler:
// FSM state enumeration, LFSR seed/taps and the LFSR step function.
package reaction_round_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_MEASURE,
        ST_SHOW,
        ST_FOUL,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Maximal-length polynomial x^16 + x^14 + x^13 + x^11 + 1 (right-shift Galois form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/reaction_round_scheduler_if.sv
// Button/tick inputs and game status outputs of the reaction round scheduler.
// Optional feature macro: ROUND_AVERAGE_EN adds the avg_ms signal.
interface reaction_round_scheduler_if;

    logic        tick_1ms;
    logic        start_btn;
    logic        react_btn;
    logic        led_on;
    logic        digits_on;
    logic        busy;
    logic [2:0]  round_idx;
    logic [15:0] result_ms;
    logic        result_valid;
    logic [15:0] best_ms;
    logic        false_start;
    logic        done;
`ifdef ROUND_AVERAGE_EN
    logic [15:0] avg_ms;
`endif

    modport master (
        output tick_1ms, start_btn, react_btn,
        input  led_on, digits_on, busy, round_idx, result_ms, result_valid,
        input  best_ms, false_start, done
`ifdef ROUND_AVERAGE_EN
        , input avg_ms
`endif
    );

    modport slave (
        input  tick_1ms, start_btn, react_btn,
        output led_on, digits_on, busy, round_idx, result_ms, result_valid,
        output best_ms, false_start, done
`ifdef ROUND_AVERAGE_EN
        , output avg_ms
`endif
    );

endinterface

// File: rtl/reaction_round_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR used to randomise the pre-stimulus delay.
module lfsr16
    import reaction_round_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_reg;

    // Advance one step every clock; a non-zero seed keeps it off the all-zero lockup state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= LFSR_SEED;
        end else begin
            q_reg <= lfsr_next(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reaction_round_scheduler.sv
// Reaction-time game sequencer: random delay, stimulus LED, timed capture,
// result display, false-start handling and best-of-series tracking.
// Optional feature macro: ROUND_AVERAGE_EN (series average on avg_ms).
module reaction_round_scheduler
    import reaction_round_scheduler_pkg::*;
#(
    parameter int NUM_ROUNDS       = 4,
    parameter int MIN_DELAY_MS     = 1000,
    parameter int DELAY_RANGE_LOG2 = 11,
    parameter int SHOW_MS          = 2000,
    parameter int MAX_MS           = 9999
) (
    input logic                   clk,
    input logic                   reset,
    reaction_round_scheduler_if.slave bus
);

    localparam logic [15:0] MAX_VAL    = 16'(MAX_MS);
    localparam logic [15:0] SHOW_LAST  = 16'(SHOW_MS - 1);
    localparam logic [2:0]  LAST_ROUND = 3'(NUM_ROUNDS - 1);
    localparam int          AVG_SHIFT  = $clog2(NUM_ROUNDS);

    state_t      state_reg;
    logic [15:0] delay_cnt_reg;
    logic [15:0] ms_cnt_reg;
    logic [15:0] show_cnt_reg;
    logic        start_prev_reg;
    logic        react_prev_reg;
    logic        led_on_reg;
    logic        digits_on_reg;
    logic        busy_reg;
    logic        result_valid_reg;
    logic        false_start_reg;
    logic        done_reg;
    logic [2:0]  round_idx_reg;
    logic [15:0] result_ms_reg;
    logic [15:0] best_ms_reg;

    logic [15:0] lfsr_q;
    logic [15:0] delay_load;
    logic        start_edge;
    logic        react_edge;
    logic        start_go;
    logic        capture;
    logic [15:0] capture_val;
    logic        show_exit;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign delay_load  = 16'(MIN_DELAY_MS) + 16'(lfsr_q[DELAY_RANGE_LOG2-1:0]);
    assign start_edge  = bus.start_btn & ~start_prev_reg;
    assign react_edge  = bus.react_btn & ~react_prev_reg;
    assign start_go    = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start_edge;
    // A react edge wins over a coincident tick so the pre-increment count is captured
    assign capture     = (state_reg == ST_MEASURE) &&
                         (react_edge || (bus.tick_1ms && (ms_cnt_reg >= MAX_VAL - 16'd1)));
    assign capture_val = react_edge ? ms_cnt_reg : MAX_VAL;
    assign show_exit   = (state_reg == ST_SHOW) && bus.tick_1ms && (show_cnt_reg == SHOW_LAST);

    // Game FSM with all status outputs registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            delay_cnt_reg    <= '0;
            ms_cnt_reg       <= '0;
            show_cnt_reg     <= '0;
            start_prev_reg   <= 1'b0;
            react_prev_reg   <= 1'b0;
            led_on_reg       <= 1'b0;
            digits_on_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            false_start_reg  <= 1'b0;
            done_reg         <= 1'b0;
            round_idx_reg    <= '0;
            result_ms_reg    <= '0;
            best_ms_reg      <= MAX_VAL;
        end else begin
            start_prev_reg   <= bus.start_btn;
            react_prev_reg   <= bus.react_btn;
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        round_idx_reg <= '0;
                        best_ms_reg   <= MAX_VAL;
                        delay_cnt_reg <= delay_load;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        digits_on_reg <= 1'b0;
                        state_reg     <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (react_edge) begin
                        led_on_reg      <= 1'b0;
                        false_start_reg <= 1'b1;
                        show_cnt_reg    <= '0;
                        state_reg       <= ST_FOUL;
                    end else if (bus.tick_1ms) begin
                        if (delay_cnt_reg != 16'd0) begin
                            delay_cnt_reg <= delay_cnt_reg - 16'd1;
                        end
                        if (delay_cnt_reg <= 16'd1) begin
                            ms_cnt_reg <= '0;
                            led_on_reg <= 1'b1;
                            state_reg  <= ST_MEASURE;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (capture) begin
                        result_ms_reg    <= capture_val;
                        result_valid_reg <= 1'b1;
                        led_on_reg       <= 1'b0;
                        digits_on_reg    <= 1'b1;
                        show_cnt_reg     <= '0;
                        if (capture_val < best_ms_reg) begin
                            best_ms_reg <= capture_val;
                        end
                        state_reg <= ST_SHOW;
                    end else if (bus.tick_1ms && (ms_cnt_reg < MAX_VAL)) begin
                        ms_cnt_reg <= ms_cnt_reg + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (show_exit) begin
                        show_cnt_reg <= '0;
                        if (round_idx_reg == LAST_ROUND) begin
                            done_reg      <= 1'b1;
                            digits_on_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            digits_on_reg <= 1'b0;
                            round_idx_reg <= round_idx_reg + 3'd1;
                            delay_cnt_reg <= delay_load;
                            state_reg     <= ST_DELAY;
                        end
                    end else if (bus.tick_1ms) begin
                        show_cnt_reg <= show_cnt_reg + 16'd1;
                    end
                end
                ST_FOUL: begin
                    if (bus.tick_1ms) begin
                        if (show_cnt_reg == SHOW_LAST) begin
                            false_start_reg <= 1'b0;
                            busy_reg        <= 1'b0;
                            show_cnt_reg    <= '0;
                            state_reg       <= ST_IDLE;
                        end else begin
                            show_cnt_reg <= show_cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The randomiser must never lock up in the all-zero state
    assert property (@(posedge clk) disable iff (reset) lfsr_q != 16'h0000);

`ifdef ROUND_AVERAGE_EN
    logic [18:0] sum_reg;
    logic [15:0] avg_ms_reg;

    // Accumulate each capture; publish the average as the series completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg    <= '0;
            avg_ms_reg <= '0;
        end else if (start_go) begin
            sum_reg    <= '0;
            avg_ms_reg <= '0;
        end else if (capture) begin
            sum_reg <= sum_reg + 19'(capture_val);
        end else if (show_exit && (round_idx_reg == LAST_ROUND)) begin
            avg_ms_reg <= 16'(sum_reg >> AVG_SHIFT);
        end
    end

    assign bus.avg_ms = avg_ms_reg;
`endif

    assign bus.led_on       = led_on_reg;
    assign bus.digits_on    = digits_on_reg;
    assign bus.busy         = busy_reg;
    assign bus.round_idx    = round_idx_reg;
    assign bus.result_ms    = result_ms_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.best_ms      = best_ms_reg;
    assign bus.false_start  = false_start_reg;
    assign bus.done         = done_reg;

endmodule

// File: tb/tb_reaction_round_scheduler.sv
// Self-checking bench for reaction_round_scheduler: directed game scenarios
// with literal expectations, then randomized play against a behavioural model.
module tb_reaction_round_scheduler;

    localparam int NR    = 2;
    localparam int MIN_D = 4;
    localparam int RL    = 2;
    localparam int SHOW  = 3;
    localparam int MAXV  = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reaction_round_scheduler_if bus_if ();

    reaction_round_scheduler #(
        .NUM_ROUNDS       (NR),
        .MIN_DELAY_MS     (MIN_D),
        .DELAY_RANGE_LOG2 (RL),
        .SHOW_MS          (SHOW),
        .MAX_MS           (MAXV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_DELAY, P_MEAS, P_SHOW, P_FOUL, P_DONE} phase_t;
    phase_t      m_phase;
    int          m_left, m_elapsed, m_hold, m_round, m_best, m_result, m_sum;
    bit          m_valid, m_sp, m_rp;
    logic [15:0] m_lfsr;

    initial begin
        bit s_e, r_e, cap;
        int cap_v;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_phase = P_IDLE; m_left = 0; m_elapsed = 0; m_hold = 0; m_round = 0;
                m_best = MAXV; m_result = 0; m_sum = 0; m_valid = 0; m_sp = 0; m_rp = 0;
                m_lfsr = 16'hACE1;
            end else begin
                s_e = bus_if.start_btn && !m_sp;
                r_e = bus_if.react_btn && !m_rp;
                m_valid = 0;
                cap = 0;
                cap_v = 0;
                case (m_phase)
                    P_IDLE, P_DONE: if (s_e) begin
                        m_round = 0; m_best = MAXV; m_sum = 0;
                        m_left = MIN_D + int'(m_lfsr[RL-1:0]);
                        m_phase = P_DELAY;
                    end
                    P_DELAY: if (r_e) begin
                        m_phase = P_FOUL; m_hold = 0;
                    end else if (bus_if.tick_1ms) begin
                        m_left--;
                        if (m_left <= 0) begin m_phase = P_MEAS; m_elapsed = 0; end
                    end
                    P_MEAS: if (r_e) begin
                        cap = 1; cap_v = m_elapsed;
                    end else if (bus_if.tick_1ms) begin
                        m_elapsed++;
                        if (m_elapsed >= MAXV) begin cap = 1; cap_v = MAXV; end
                    end
                    P_SHOW: if (bus_if.tick_1ms) begin
                        m_hold++;
                        if (m_hold == SHOW) begin
                            if (m_round == NR - 1) m_phase = P_DONE;
                            else begin
                                m_round++;
                                m_left = MIN_D + int'(m_lfsr[RL-1:0]);
                                m_phase = P_DELAY;
                            end
                        end
                    end
                    P_FOUL: if (bus_if.tick_1ms) begin
                        m_hold++;
                        if (m_hold == SHOW) m_phase = P_IDLE;
                    end
                    default: m_phase = P_IDLE;
                endcase
                if (cap) begin
                    m_result = cap_v; m_valid = 1; m_sum += cap_v;
                    if (cap_v < m_best) m_best = cap_v;
                    m_phase = P_SHOW; m_hold = 0;
                end
                m_sp = bus_if.start_btn;
                m_rp = bus_if.react_btn;
                m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("led_on",       bus_if.led_on,       m_phase == P_MEAS);
        chk("digits_on",    bus_if.digits_on,    (m_phase == P_SHOW) || (m_phase == P_DONE));
        chk("busy",         bus_if.busy,         m_phase != P_IDLE);
        chk("false_start",  bus_if.false_start,  m_phase == P_FOUL);
        chk("done",         bus_if.done,         m_phase == P_DONE);
        chk("round_idx",    bus_if.round_idx,    m_round);
        chk("result_ms",    bus_if.result_ms,    m_result);
        chk("result_valid", bus_if.result_valid, m_valid);
        chk("best_ms",      bus_if.best_ms,      m_best);
`ifdef ROUND_AVERAGE_EN
        chk("avg_ms",       bus_if.avg_ms,       (m_phase == P_DONE) ? (m_sum >> $clog2(NR)) : 0);
`endif
        if (bus_if.result_valid === 1'b1)
            $display("capture round=%0d result_ms=%0d best_ms=%0d", bus_if.round_idx, bus_if.result_ms, bus_if.best_ms);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic t, input logic s, input logic r);
        bus_if.tick_1ms  = t;
        bus_if.start_btn = s;
        bus_if.react_btn = r;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); end
    endtask

    task automatic press_start();
        cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (bus_if.led_on !== 1'b1 && n < 40) begin
            cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int  n;
        logic t, s, r;
        bus_if.tick_1ms = 1'b0; bus_if.start_btn = 1'b0; bus_if.react_btn = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_best", bus_if.best_ms, 20);
        chk("rst_led", bus_if.led_on, 0);
        chk("rst_result", bus_if.result_ms, 0);
        reset = 1'b0;
        @(negedge clk);

        // Series 1: results 5 then 3
        cyc(1'b0, 1'b1, 1'b0);
        chk("start_busy", bus_if.busy, 1);
        cyc(1'b0, 1'b0, 1'b0);
        wait_led(n);
        chk("delay_in_4_to_7", (n >= 4 && n <= 7), 1);
        ticks(5);
        cyc(1'b0, 1'b0, 1'b1);
        chk("r0_result", bus_if.result_ms, 5);
        chk("r0_valid", bus_if.result_valid, 1);
        chk("r0_best", bus_if.best_ms, 5);
        chk("r0_digits", bus_if.digits_on, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("r0_valid_pulse", bus_if.result_valid, 0);
        ticks(2);
        chk("r0_show_hold", bus_if.digits_on, 1);
        ticks(1);
        chk("r0_show_end", bus_if.digits_on, 0);
        chk("r1_round", bus_if.round_idx, 1);
        wait_led(n);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1);
        chk("r1_result", bus_if.result_ms, 3);
        chk("r1_best", bus_if.best_ms, 3);
        cyc(1'b0, 1'b0, 1'b0);
        ticks(3);
        chk("done", bus_if.done, 1);
        chk("done_round", bus_if.round_idx, 1);
        chk("done_best", bus_if.best_ms, 3);
`ifdef ROUND_AVERAGE_EN
        chk("done_avg", bus_if.avg_ms, 4);
`endif

        // False start; start edge during FOUL ignored
        press_start();
        chk("restart_done", bus_if.done, 0);
        ticks(1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("foul_flag", bus_if.false_start, 1);
        chk("foul_led", bus_if.led_on, 0);
        cyc(1'b0, 1'b0, 1'b0);
        ticks(1);
        press_start();
        ticks(1);
        chk("foul_hold", bus_if.false_start, 1);
        ticks(1);
        chk("foul_idle", bus_if.busy, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("foul_start_ignored", bus_if.busy, 0);

        // Timeout capture, then a react edge coincident with a tick
        press_start();
        wait_led(n);
        ticks(19);
        chk("pre_timeout_led", bus_if.led_on, 1);
        ticks(1);
        chk("timeout_result", bus_if.result_ms, 20);
        chk("timeout_show", bus_if.digits_on, 1);
        ticks(3);
        wait_led(n);
        ticks(7);
        cyc(1'b1, 1'b0, 1'b1);
        chk("coincident_result", bus_if.result_ms, 7);
        chk("coincident_best", bus_if.best_ms, 7);
        cyc(1'b0, 1'b0, 1'b0);
        ticks(3);

        // Reset mid-measurement
        press_start();
        wait_led(n);
        ticks(2);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", bus_if.busy, 0);
        chk("mid_rst_led", bus_if.led_on, 0);
        chk("mid_rst_best", bus_if.best_ms, 20);
        chk("mid_rst_result", bus_if.result_ms, 0);
        chk("mid_rst_round", bus_if.round_idx, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Randomized play checked by the model
        for (int i = 0; i < 6000; i++) begin
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1999) == 0) begin
                #1 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
            cyc(t, s, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_round_scheduler.md
REACTION_ROUND_SCHEDULER -- requirements
Module: reaction_round_scheduler

Interface
REQ-001 Parameter NUM_ROUNDS, default 4, rounds per series; power of two, 1..8.
REQ-002 Parameter MIN_DELAY_MS, default 1000, fixed part of the pre-stimulus delay in ms.
REQ-003 Parameter DELAY_RANGE_LOG2, default 11, width of the random part of the delay (0..2^N-1 ms).
REQ-004 Parameter SHOW_MS, default 2000, result display hold time in ms.
REQ-005 Parameter MAX_MS, default 9999, measurement saturation and timeout value.
REQ-006 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port tick_1ms  input  1  one-clk strobe per millisecond.
REQ-009 Port start_btn  input  1  synchronized, debounced start level.
REQ-010 Port react_btn  input  1  synchronized, debounced reaction level.
REQ-011 Port led_on  output  1  stimulus LED.
REQ-012 Port digits_on  output  1  display enable.
REQ-013 Port busy  output  1  high when the FSM is in any state other than IDLE.
REQ-014 Port round_idx  output  3  current round, 0-based.
REQ-015 Port result_ms  output  16  last captured reaction time.
REQ-016 Port result_valid  output  1  one-clk pulse on each capture.
REQ-017 Port best_ms  output  16  minimum result in the current series.
REQ-018 Port false_start  output  1  high while in FOUL.
REQ-019 Port done  output  1  high while in DONE.

Function
REQ-020 Rising edges of start_btn and react_btn shall be detected internally against a registered previous value; levels shall have no effect.
REQ-021 States shall be IDLE, DELAY, MEASURE, SHOW, FOUL and DONE.
REQ-022 Delay load: delay_cnt = MIN_DELAY_MS + lfsr[DELAY_RANGE_LOG2-1:0], sampled in the same cycle as the transition into DELAY.
REQ-023 IDLE: a start edge shall set round_idx=0, clear best_ms to MAX_MS, load the delay and enter DELAY.
REQ-024 DELAY: decrement delay_cnt on each tick; on the tick at which delay_cnt reaches 0, enter MEASURE with ms_cnt=0 and led_on=1 from the next cycle.
REQ-025 DELAY: a react edge, including one in the same cycle as the expiry tick, shall enter FOUL with led_on=0.
REQ-026 MEASURE: increment ms_cnt on each tick, saturating at MAX_MS.
REQ-027 MEASURE capture: a react edge shall set result_ms=ms_cnt, pulse result_valid for one cycle, set led_on=0 and digits_on=1, update best_ms if result_ms<best_ms, and enter SHOW.
REQ-028 A react edge coincident with a tick shall capture the pre-increment ms_cnt.
REQ-029 If ms_cnt reaches MAX_MS with no react edge, capture MAX_MS exactly as in REQ-027.
REQ-030 SHOW: hold for SHOW_MS ticks, then clear digits_on.
REQ-031 SHOW exit on the last round (round_idx==NUM_ROUNDS-1): enter DONE.
REQ-032 SHOW exit on any other round: increment round_idx, reload the delay and enter DELAY.
REQ-033 FOUL: hold for SHOW_MS ticks, then enter IDLE; the series is aborted and start edges are ignored.
REQ-034 DONE: digits_on=1 and done=1; a start edge shall behave as in REQ-023.
REQ-035 react_btn edges in IDLE, SHOW and DONE shall be ignored.
REQ-036 A 16-bit Galois LFSR shall advance every clk cycle from seed 16'hACE1 and shall never reach the all-zero state.

Reset
REQ-037 Reset shall force IDLE, all outputs to 0, best_ms to MAX_MS, all counters to 0 and the LFSR to its seed, asynchronously; release takes effect at the next clk edge.
REQ-038 Reset asserted mid-series shall discard all results.

Configuration
REQ-039 With ROUND_AVERAGE_EN defined, a 19-bit accumulator shall sum the captured results, and an output avg_ms[15:0] shall equal sum>>log2(NUM_ROUNDS), valid from DONE entry and cleared on the REQ-023 start.
REQ-040 Without ROUND_AVERAGE_EN, neither the accumulator nor the avg_ms port shall exist.

Structure
REQ-041 A shared package shall hold the state enumeration, the LFSR seed and the LFSR tap constants.
REQ-042 The LFSR shall be a sub-module named lfsr16 with ports clk, reset and q[15:0].

Verification (NUM_ROUNDS=2, MIN_DELAY_MS=4, DELAY_RANGE_LOG2=2, SHOW_MS=3, MAX_MS=20)
REQ-043 Reset then start edge -> busy=1, DELAY, led_on=1 after 4..7 ticks.
REQ-044 React edge 5 ticks after led_on -> result_ms=5, one-clk result_valid, best_ms=5, digits_on=1 for 3 ticks.
REQ-045 Round 0 result 5, round 1 result 3 -> best_ms=3, done=1, round_idx=1; with ROUND_AVERAGE_EN, avg_ms=4.
REQ-046 React edge during DELAY -> false_start=1, led_on=0; IDLE after 3 ticks; a start edge during FOUL is ignored.
REQ-047 No react for 20 ticks in MEASURE -> result_ms=20 and SHOW entered; react edge coincident with the tick at ms_cnt=7 -> result_ms=7.
REQ-048 Reset asserted in MEASURE -> immediate IDLE with all outputs 0 and best_ms=20.
